// File: rtl/sprite_feeder_if.sv
// Renderer handshake bundle: the feeder drives descriptors, the renderer
// answers with sprite_ready.
interface sprite_feeder_if #(
  parameter int XW = 9,
  parameter int YW = 10,
  parameter int FW = 9
);
  logic          sprite_valid;
  logic          sprite_ready;
  logic [XW-1:0] sprite_x;
  logic [YW-1:0] sprite_y;
  logic [FW-1:0] sprite_frame_number;

  modport master (
    output sprite_valid,
    output sprite_x,
    output sprite_y,
    output sprite_frame_number,
    input  sprite_ready
  );

  modport slave (
    input  sprite_valid,
    input  sprite_x,
    input  sprite_y,
    input  sprite_frame_number,
    output sprite_ready
  );
endinterface

// File: rtl/sprite_feeder.sv
// Per-frame sprite descriptor issuer. Holds a register-based sprite table,
// advances animation phases on frame boundaries and walks the table once per
// frame, handing each active, in-bounds sprite to the renderer.
module sprite_feeder #(
  parameter int MAX_SPRITES         = 16,
  parameter int NUM_FRAMES          = 512,
  parameter int CANVAS_WIDTH        = 360,
  parameter int CANVAS_HEIGHT       = 720,
  parameter int SPRITE_FRAME_WIDTH  = 64,
  parameter int SPRITE_FRAME_HEIGHT = 64,
  parameter int ANIM_SHIFT          = 2,
  parameter int MAX_ANIM            = 8,
  localparam int IW = $clog2(MAX_SPRITES),
  localparam int XW = $clog2(CANVAS_WIDTH),
  localparam int YW = $clog2(CANVAS_HEIGHT),
  localparam int FW = $clog2(NUM_FRAMES),
  localparam int LW = $clog2(MAX_ANIM) + 1
) (
  input  logic          clk_pixel,
  input  logic          sys_rst,
  input  logic [5:0]    frame_count,
  input  logic          tbl_we,
  input  logic [IW-1:0] tbl_addr,
  input  logic          tbl_active,
  input  logic [XW-1:0] tbl_x,
  input  logic [YW-1:0] tbl_y,
  input  logic [FW-1:0] tbl_base,
  input  logic [LW-1:0] tbl_len,
  sprite_feeder_if.master spr,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    overrun_count
);

  // Walk index needs one extra code point to mark "past the last entry".
  localparam int CW = $clog2(MAX_SPRITES + 1);
  localparam logic [XW-1:0] X_LIMIT = XW'(CANVAS_WIDTH - SPRITE_FRAME_WIDTH);
  localparam logic [YW-1:0] Y_LIMIT = YW'(CANVAS_HEIGHT - SPRITE_FRAME_HEIGHT);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   idx_reg, idx_next;
  logic [5:0]      prev_fc_reg;
  logic [ANIM_SHIFT-1:0] anim_cnt_reg;

  logic            active_reg [MAX_SPRITES];
  logic [XW-1:0]   x_reg      [MAX_SPRITES];
  logic [YW-1:0]   y_reg      [MAX_SPRITES];
  logic [FW-1:0]   base_reg   [MAX_SPRITES];
  logic [LW-1:0]   len_reg    [MAX_SPRITES];
  logic [LW-1:0]   phase_reg  [MAX_SPRITES];
  logic [LW-1:0]   phase_adv  [MAX_SPRITES];

  logic            valid_reg;
  logic [XW-1:0]   sx_reg;
  logic [YW-1:0]   sy_reg;
  logic [FW-1:0]   sfn_reg;
  logic            done_reg, done_next;
  logic [7:0]      overrun_reg;
  logic            issue, overrun;

  logic            boundary, anim_tick, walk_end, cur_eligible;
  logic [IW-1:0]   cur;

  assign boundary  = (frame_count != prev_fc_reg);
  assign anim_tick = boundary && (&anim_cnt_reg);
  assign walk_end  = (idx_reg == CW'(MAX_SPRITES));
  assign cur       = idx_reg[IW-1:0];
  assign cur_eligible = active_reg[cur] && (x_reg[cur] <= X_LIMIT) &&
                        (y_reg[cur] <= Y_LIMIT);

  // Per-entry next animation phase: wrap to 0 at the (zero-means-one) length.
  for (genvar gi = 0; gi < MAX_SPRITES; gi++) begin : g_phase
    logic [LW:0]   inc;
    logic [LW-1:0] len_eff;
    assign len_eff = (len_reg[gi] == '0) ? LW'(1) : len_reg[gi];
    assign inc     = {1'b0, phase_reg[gi]} + (LW+1)'(1);
    assign phase_adv[gi] = (inc >= {1'b0, len_eff}) ? '0 : inc[LW-1:0];
  end

  // Table storage: a write replaces the entry and restarts its animation,
  // taking precedence over a same-cycle animation tick.
  always_ff @(posedge clk_pixel or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < MAX_SPRITES; i++) begin
        active_reg[i] <= 1'b0;
        x_reg[i]      <= '0;
        y_reg[i]      <= '0;
        base_reg[i]   <= '0;
        len_reg[i]    <= '0;
        phase_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_SPRITES; i++) begin
        if (tbl_we && (tbl_addr == IW'(i))) begin
          active_reg[i] <= tbl_active;
          x_reg[i]      <= tbl_x;
          y_reg[i]      <= tbl_y;
          base_reg[i]   <= tbl_base;
          len_reg[i]    <= tbl_len;
          phase_reg[i]  <= '0;
        end else if (anim_tick && active_reg[i]) begin
          phase_reg[i]  <= phase_adv[i];
        end
      end
    end
  end

  // Walk sequencer: a boundary always wins and restarts the walk at entry 0;
  // an issue is followed by a HOLD cycle so a stale ready is never reused.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    issue      = 1'b0;
    done_next  = 1'b0;
    overrun    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (boundary) begin
          state_next = SCAN;
          idx_next   = '0;
        end
      end
      SCAN: begin
        if (boundary) begin
          idx_next = '0;
          overrun  = 1'b1;
        end else if (walk_end) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (!cur_eligible) begin
          idx_next = idx_reg + CW'(1);
        end else if (spr.sprite_ready) begin
          issue      = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        state_next = SCAN;
        if (boundary) begin
          idx_next = '0;
          overrun  = 1'b1;
        end else begin
          idx_next = idx_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state, boundary edge detect and animation prescaler.
  always_ff @(posedge clk_pixel or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      prev_fc_reg  <= '0;
      anim_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      prev_fc_reg <= frame_count;
      if (boundary) anim_cnt_reg <= anim_cnt_reg + ANIM_SHIFT'(1);
    end
  end

  // Registered outputs: descriptor loads only on issue and then holds.
  always_ff @(posedge clk_pixel or posedge sys_rst) begin
    if (sys_rst) begin
      valid_reg   <= 1'b0;
      sx_reg      <= '0;
      sy_reg      <= '0;
      sfn_reg     <= '0;
      done_reg    <= 1'b0;
      overrun_reg <= '0;
    end else begin
      valid_reg <= issue;
      done_reg  <= done_next;
      if (issue) begin
        sx_reg  <= x_reg[cur];
        sy_reg  <= y_reg[cur];
        sfn_reg <= base_reg[cur] + FW'(phase_reg[cur]);
      end
      if (overrun && (overrun_reg != 8'hFF)) overrun_reg <= overrun_reg + 8'd1;
    end
  end

  assign spr.sprite_valid        = valid_reg;
  assign spr.sprite_x            = sx_reg;
  assign spr.sprite_y            = sy_reg;
  assign spr.sprite_frame_number = sfn_reg;
  assign busy                    = (state_reg != IDLE);
  assign frame_done              = done_reg;
  assign overrun_count           = overrun_reg;

endmodule

// File: tb/tb_sprite_feeder.sv
// Self-checking bench for sprite_feeder: table-driven single-entry vectors,
// hand-written timing sequences and randomized walks against a frame-level model.
module tb_sprite_feeder;
  localparam int NS = 16, XW = 9, YW = 10, FW = 9, IW = 4, LW = 4;

  logic          clk_pixel = 1'b0;
  logic          sys_rst = 1'b1;
  logic [5:0]    frame_count = '0;
  logic          tbl_we = 1'b0;
  logic [IW-1:0] tbl_addr = '0;
  logic          tbl_active = 1'b0;
  logic [XW-1:0] tbl_x = '0;
  logic [YW-1:0] tbl_y = '0;
  logic [FW-1:0] tbl_base = '0;
  logic [LW-1:0] tbl_len = '0;
  logic          busy, frame_done;
  logic [7:0]    overrun_count;

  sprite_feeder_if #(.XW(XW), .YW(YW), .FW(FW)) spr ();

  sprite_feeder dut (
    .clk_pixel(clk_pixel), .sys_rst(sys_rst), .frame_count(frame_count),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_active(tbl_active),
    .tbl_x(tbl_x), .tbl_y(tbl_y), .tbl_base(tbl_base), .tbl_len(tbl_len),
    .spr(spr), .busy(busy), .frame_done(frame_done),
    .overrun_count(overrun_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  int cyc = 0;
  always @(posedge clk_pixel) cyc <= cyc + 1;

  typedef struct { int c; int x; int y; int fn; } iss_t;
  iss_t iss_q[$];
  iss_t exp_q[$];
  int   done_q[$];

  int n_checks = 0, n_fail = 0;
  bit rand_ready = 0;
  bit prev_valid = 0, prev_ready = 0;
  int bstamp;

  // Frame-level reference model of the table and animation clock.
  bit m_act[NS];
  int m_x[NS], m_y[NS], m_base[NS], m_len[NS], m_tw[NS];
  int bcount, ticks;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: logs each issue and checks pulse width and handshake legality.
  always @(negedge clk_pixel) begin
    if (spr.sprite_valid) begin
      chk("valid_single_cycle", int'(prev_valid), 0);
      chk("ready_before_valid", int'(prev_ready), 1);
      iss_q.push_back('{cyc, int'(spr.sprite_x), int'(spr.sprite_y),
                        int'(spr.sprite_frame_number)});
      $display("issue  cyc=%0d x=%0d y=%0d frame=%0d", cyc, spr.sprite_x,
               spr.sprite_y, spr.sprite_frame_number);
    end
    if (frame_done) done_q.push_back(cyc);
    prev_valid = spr.sprite_valid;
    prev_ready = spr.sprite_ready;
  end

  task automatic step();
    @(posedge clk_pixel);
    #1;
    if (rand_ready) spr.sprite_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_base[i] = 0; m_len[i] = 0; m_tw[i] = 0;
    end
    bcount = 0;
    ticks  = 0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    #1;
    chk("rst_valid", int'(spr.sprite_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_overrun", int'(overrun_count), 0);
    chk("rst_desc", int'(spr.sprite_x) + int'(spr.sprite_y) + int'(spr.sprite_frame_number), 0);
    frame_count = '0;
    tbl_we = 1'b0;
    step(); step();
    model_clear();
    sys_rst = 1'b0;
    step();
  endtask

  task automatic wr(int a, bit act, int x, int y, int base, int len);
    tbl_addr = IW'(a); tbl_active = act; tbl_x = XW'(x); tbl_y = YW'(y);
    tbl_base = FW'(base); tbl_len = LW'(len); tbl_we = 1'b1;
    step();
    tbl_we = 1'b0;
    m_act[a] = act; m_x[a] = x; m_y[a] = y; m_base[a] = base; m_len[a] = len;
    m_tw[a] = ticks;
  endtask

  // Change frame_count; the model counts boundaries and animation ticks.
  task automatic boundary();
    frame_count = frame_count + 6'd1;
    bcount++;
    if (bcount % 4 == 0) ticks++;
    bstamp = cyc;
    step();
  endtask

  task automatic model_walk();
    int le;
    exp_q.delete();
    for (int i = 0; i < NS; i++) begin
      if (m_act[i] && m_x[i] <= 360 - 64 && m_y[i] <= 720 - 64) begin
        le = (m_len[i] == 0) ? 1 : m_len[i];
        exp_q.push_back('{0, m_x[i], m_y[i], (m_base[i] + (ticks - m_tw[i]) % le) % 512});
      end
    end
  endtask

  task automatic wait_issues(int n, int lim);
    for (int i = 0; i < lim && iss_q.size() < n; i++) step();
    chk("issue_wait", int'(iss_q.size() >= n), 1);
  endtask

  task automatic wait_done(int n, int lim);
    for (int i = 0; i < lim && done_q.size() < n; i++) step();
    chk("done_wait", int'(done_q.size() >= n), 1);
  endtask

  typedef struct { bit act; int x; int y; int base; int len; int exp_issue; int exp_fn; } vec_t;
  vec_t vecs[8];
  int anim_exp[16];

  initial begin
    int d0;
    vecs[0] = '{1, 10, 20, 5, 1, 1, 5};
    vecs[1] = '{0, 10, 20, 5, 1, 0, 0};
    vecs[2] = '{1, 296, 0, 7, 1, 1, 7};
    vecs[3] = '{1, 297, 0, 7, 1, 0, 0};
    vecs[4] = '{1, 0, 656, 9, 0, 1, 9};
    vecs[5] = '{1, 0, 657, 9, 1, 0, 0};
    vecs[6] = '{1, 359, 719, 3, 1, 0, 0};
    vecs[7] = '{1, 0, 0, 511, 1, 1, 511};
    anim_exp = '{40, 40, 40, 41, 41, 41, 41, 42, 42, 42, 42, 40, 40, 40, 40, 41};
    spr.sprite_ready = 1'b0;

    // Single sprite: latency and frame_done timing.
    do_reset();
    wr(0, 1, 10, 20, 5, 1);
    spr.sprite_ready = 1'b1;
    iss_q.delete(); d0 = done_q.size();
    boundary();
    wait_done(d0 + 1, 100);
    chk("single_n", iss_q.size(), 1);
    if (iss_q.size() > 0 && done_q.size() > d0) begin
      chk("single_latency", iss_q[0].c - bstamp, 2);
      chk("single_x", iss_q[0].x, 10);
      chk("single_y", iss_q[0].y, 20);
      chk("single_fn", iss_q[0].fn, 5);
      chk("single_done_delay", done_q[d0] - iss_q[0].c, NS + 1);
    end

    // Table-driven eligibility / frame-number vectors on entry 0.
    foreach (vecs[v]) begin
      wr(0, vecs[v].act, vecs[v].x, vecs[v].y, vecs[v].base, vecs[v].len);
      iss_q.delete(); d0 = done_q.size();
      boundary();
      wait_done(d0 + 1, 100);
      chk($sformatf("vec%0d_n", v), iss_q.size(), vecs[v].exp_issue);
      if (vecs[v].exp_issue == 1 && iss_q.size() == 1) begin
        chk($sformatf("vec%0d_x", v), iss_q[0].x, vecs[v].x);
        chk($sformatf("vec%0d_y", v), iss_q[0].y, vecs[v].y);
        chk($sformatf("vec%0d_fn", v), iss_q[0].fn, vecs[v].exp_fn);
      end
    end

    // Skip rules.
    do_reset();
    wr(0, 0, 10, 20, 1, 1);
    wr(1, 1, 300, 20, 2, 1);
    wr(2, 1, 10, 656, 3, 1);
    wr(3, 1, 10, 30, 4, 1);
    iss_q.delete(); d0 = done_q.size();
    boundary();
    wait_done(d0 + 1, 100);
    chk("skip_n", iss_q.size(), 2);
    if (iss_q.size() == 2) begin
      chk("skip_first_y", iss_q[0].y, 656);
      chk("skip_first_fn", iss_q[0].fn, 3);
      chk("skip_second_y", iss_q[1].y, 30);
      chk("skip_second_fn", iss_q[1].fn, 4);
    end

    // Handshake: renderer busy for 100 cycles after the first issue.
    do_reset();
    wr(0, 1, 11, 21, 1, 1);
    wr(1, 1, 12, 22, 2, 1);
    iss_q.delete();
    boundary();
    step();
    chk("hs_first_valid", int'(spr.sprite_valid), 1);
    spr.sprite_ready = 1'b0;
    repeat (100) step();
    chk("hs_stall_n", iss_q.size(), 1);
    chk("hs_stall_busy", int'(busy), 1);
    spr.sprite_ready = 1'b1;
    wait_issues(2, 20);
    if (iss_q.size() >= 2) chk("hs_second_x", iss_q[1].x, 12);

    // Animation across 16 boundaries.
    do_reset();
    wr(0, 1, 10, 20, 40, 3);
    for (int b = 0; b < 16; b++) begin
      iss_q.delete(); d0 = done_q.size();
      boundary();
      wait_done(d0 + 1, 100);
      chk($sformatf("anim%0d_n", b), iss_q.size(), 1);
      if (iss_q.size() == 1) chk($sformatf("anim%0d_fn", b), iss_q[0].fn, anim_exp[b]);
    end

    // Overrun: second boundary while the walk is stalled on entry 1.
    do_reset();
    for (int i = 0; i < 4; i++) wr(i, 1, 10 * (i + 1), 5, i, 1);
    iss_q.delete(); d0 = done_q.size();
    boundary();
    step();
    spr.sprite_ready = 1'b0;
    repeat (10) step();
    chk("ovr_pre_n", iss_q.size(), 1);
    boundary();
    repeat (3) step();
    chk("ovr_count", int'(overrun_count), 1);
    chk("ovr_no_done", done_q.size(), d0);
    spr.sprite_ready = 1'b1;
    wait_done(d0 + 1, 200);
    chk("ovr_total_n", iss_q.size(), 5);
    if (iss_q.size() >= 2) chk("ovr_restart_x", iss_q[1].x, 10);
    chk("ovr_done_once", done_q.size(), d0 + 1);

    // Reset while sprite_valid is high.
    iss_q.delete();
    boundary();
    step();
    chk("rmid_valid_before", int'(spr.sprite_valid), 1);
    sys_rst = 1'b1;
    #1;
    chk("rmid_valid_async", int'(spr.sprite_valid), 0);
    chk("rmid_busy_async", int'(busy), 0);
    chk("rmid_overrun_async", int'(overrun_count), 0);
    frame_count = '0;
    step(); step();
    model_clear();
    sys_rst = 1'b0;
    iss_q.delete();
    repeat (20) step();
    chk("rmid_no_issue", iss_q.size(), 0);
    chk("rmid_idle", int'(busy), 0);

    // Randomized walks against the frame-level model.
    do_reset();
    rand_ready = 1;
    for (int w = 0; w < 25; w++) begin
      int nw;
      nw = $urandom_range(1, 5);
      for (int k = 0; k < nw; k++)
        wr($urandom_range(0, NS - 1), ($urandom_range(0, 4) != 0), $urandom_range(0, 359),
           $urandom_range(0, 719), $urandom_range(0, 511), $urandom_range(0, 8));
      iss_q.delete(); d0 = done_q.size();
      boundary();
      model_walk();
      wait_done(d0 + 1, 600);
      chk($sformatf("rand%0d_n", w), iss_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < iss_q.size(); k++) begin
        chk($sformatf("rand%0d_%0d_x", w, k), iss_q[k].x, exp_q[k].x);
        chk($sformatf("rand%0d_%0d_y", w, k), iss_q[k].y, exp_q[k].y);
        chk($sformatf("rand%0d_%0d_fn", w, k), iss_q[k].fn, exp_q[k].fn);
      end
    end
    rand_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
